alu_mul_sequencer: RTL and testbench



---
 rtl/alu_mul_sequencer.sv | 170 +++++++++++++++++
 tb/tb_alu_mul_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle initiator for the shared 16-bit ALU: shift-add MUL (low half kept)
// and single-step CMP, with a start/done handshake toward the control FSM.
module alu_mul_sequencer #(
  parameter int WIDTH = 16,
  parameter int ITER  = 16
) (
  input  logic             input_CLK,
  input  logic             input_Reset_n,
  input  logic             input_Start,
  input  logic [1:0]       input_Cmd,
  input  logic [WIDTH-1:0] input_Op_A,
  input  logic [WIDTH-1:0] input_Op_B,
  output logic             output_Ready,
  output logic             output_Done,
  output logic [WIDTH-1:0] output_Result,
  output logic             output_Zero,
  output logic             output_Negative,
  output logic             output_Error,
  output logic [WIDTH-1:0] output_ALU_A,
  output logic [WIDTH-1:0] output_ALU_B,
  output logic [2:0]       output_ALUOp,
  input  logic [WIDTH-1:0] input_ALU_Result,
  input  logic             input_ALU_Zero,
  input  logic             input_ALU_Negative
);

  localparam int CW = $clog2(ITER) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_MUL_ADD, S_MUL_SHIFT, S_CMP_EXEC, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d, q_q, q_d, p_q, p_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d, neg_q, neg_d, err_q, err_d;
  logic             done_q, ready_q;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]       alu_op_q, alu_op_d;

  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    q_d      = q_q;
    p_d      = p_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    err_d    = err_q;
    alu_a_d  = '0;
    alu_b_d  = '0;
    alu_op_d = 3'b000;

    case (state_q)
      S_IDLE: begin
        if (input_Start) begin
          m_d   = input_Op_A;
          q_d   = input_Op_B;
          p_d   = '0;
          cnt_d = '0;
          err_d = 1'b0;
          case (input_Cmd)
            2'b00:   state_d = S_MUL_ADD;
            2'b01:   state_d = S_CMP_EXEC;
            default: begin
              state_d  = S_DONE;
              result_d = '0;
              zero_d   = 1'b1;
              neg_d    = 1'b0;
              err_d    = 1'b1;
            end
          endcase
        end
      end
      S_MUL_ADD: begin
        if (q_q[0]) p_d = input_ALU_Result;
        state_d = S_MUL_SHIFT;
      end
      S_MUL_SHIFT: begin
        m_d   = input_ALU_Result;
        q_d   = q_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ITER - 1)) begin
          state_d  = S_DONE;
          result_d = p_q;
          zero_d   = (p_q == '0);
          neg_d    = p_q[WIDTH-1];
        end else begin
          state_d = S_MUL_ADD;
        end
      end
      S_CMP_EXEC: begin
        result_d = input_ALU_Result;
        zero_d   = input_ALU_Zero;
        neg_d    = input_ALU_Negative;
        state_d  = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // ALU drive is registered, so decode it from the state being entered
    case (state_d)
      S_MUL_ADD: begin
        alu_a_d  = p_d;
        alu_b_d  = m_d;
        alu_op_d = 3'b000;
      end
      S_MUL_SHIFT: begin
        alu_a_d  = m_d;
        alu_b_d  = WIDTH'(1);
        alu_op_d = 3'b010;
      end
      S_CMP_EXEC: begin
        alu_a_d  = m_d;
        alu_b_d  = q_d;
        alu_op_d = 3'b001;
      end
      default: ;
    endcase
  end

  always_ff @(posedge input_CLK or negedge input_Reset_n) begin
    if (!input_Reset_n) begin
      state_q  <= S_IDLE;
      m_q      <= '0;
      q_q      <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= 3'b000;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      q_q      <= q_d;
      p_q      <= p_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      err_q    <= err_d;
      // Done trails the DONE state by one cycle, coinciding with the return to IDLE
      done_q   <= (state_q == S_DONE);
      ready_q  <= (state_d == S_IDLE);
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
    end
  end

  assign output_Ready    = ready_q;
  assign output_Done     = done_q;
  assign output_Result   = result_q;
  assign output_Zero     = zero_q;
  assign output_Negative = neg_q;
  assign output_Error    = err_q;
  assign output_ALU_A    = alu_a_q;
  assign output_ALU_B    = alu_b_q;
  assign output_ALUOp    = alu_op_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Randomized bench for alu_mul_sequencer with a combinational ALU stand-in and
// an arithmetic reference (A*B mod 2^16, A-B).
module tb_alu_mul_sequencer;

  logic        clk, rst_n;
  logic        start;
  logic [1:0]  cmd;
  logic [15:0] op_a, op_b;
  logic        ready, done, zero, neg, err;
  logic [15:0] result, alu_a, alu_b, alu_res;
  logic [2:0]  alu_op;
  logic        alu_zero, alu_neg;

  int tests_run = 0;
  int tests_failed = 0;

  alu_mul_sequencer #(.WIDTH(16), .ITER(16)) dut (
    .input_CLK          (clk),
    .input_Reset_n      (rst_n),
    .input_Start        (start),
    .input_Cmd          (cmd),
    .input_Op_A         (op_a),
    .input_Op_B         (op_b),
    .output_Ready       (ready),
    .output_Done        (done),
    .output_Result      (result),
    .output_Zero        (zero),
    .output_Negative    (neg),
    .output_Error       (err),
    .output_ALU_A       (alu_a),
    .output_ALU_B       (alu_b),
    .output_ALUOp       (alu_op),
    .input_ALU_Result   (alu_res),
    .input_ALU_Zero     (alu_zero),
    .input_ALU_Negative (alu_neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU stand-in: add, subtract, shift-left
  always_comb begin
    case (alu_op)
      3'b000:  alu_res = alu_a + alu_b;
      3'b001:  alu_res = alu_a - alu_b;
      3'b010:  alu_res = alu_a << alu_b[3:0];
      default: alu_res = 16'h0000;
    endcase
    alu_zero = (alu_res == 16'h0000);
    alu_neg  = alu_res[15];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one command, measure latency, check results against the arithmetic model.
  task automatic run_op(input logic [1:0] c, input logic [15:0] a, input logic [15:0] b,
                        input bit interfere);
    int          k, w, exp_lat, nbad, nadd, nshift;
    logic [2:0]  ops [0:63];
    logic [15:0] exp_res;
    logic        exp_err;
    w = 0;
    while (!ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("ready_before", ready, 1);
    start = 1'b1; cmd = c; op_a = a; op_b = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cmd = 2'($urandom); op_a = 16'($urandom); op_b = 16'($urandom);
    k = 0;
    while (!done && k < 60) begin
      ops[k] = alu_op;
      if (interfere && k == 5) begin
        chk("busy_ready", ready, 0);
        start = 1'b1; cmd = 2'b00; op_a = 16'($urandom); op_b = 16'($urandom);
      end else if (interfere && k == 8) begin
        start = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    start = 1'b0;

    case (c)
      2'b00: begin exp_lat = 33; exp_res = 16'((32'(a) * 32'(b)) & 32'hFFFF); exp_err = 1'b0; end
      2'b01: begin exp_lat = 2;  exp_res = a - b; exp_err = 1'b0; end
      default: begin exp_lat = 1; exp_res = 16'h0000; exp_err = 1'b1; end
    endcase
    chk("latency", k, exp_lat);
    chk("result", result, exp_res);
    chk("zero", zero, exp_res == 16'h0000);
    chk("negative", neg, exp_res[15]);
    chk("error", err, exp_err);
    chk("ready_at_done", ready, 1);

    if (c == 2'b00 && k == 33) begin
      nbad = 0; nadd = 0; nshift = 0;
      for (int i = 0; i < 32; i++) begin
        if (ops[i] == 3'b000) nadd++;
        if (ops[i] == 3'b010) nshift++;
        if (ops[i] != ((i % 2) ? 3'b010 : 3'b000)) nbad++;
      end
      chk("op_trace_bad", nbad, 0);
      chk("op_trace_adds", nadd, 16);
      chk("op_trace_shifts", nshift, 16);
    end

    @(posedge clk);
    @(negedge clk);
    chk("done_pulse", done, 0);
  endtask

  initial begin
    int lat;
    start = 1'b0; cmd = 2'b00; op_a = 16'h0; op_b = 16'h0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_result", result, 16'h0);
    chk("rst_flags", {zero, neg, err}, 3'b000);
    chk("rst_alu", {alu_a, alu_b, alu_op}, 35'h0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(2'b00, 16'd3, 16'd5, 1'b0);
    run_op(2'b00, 16'h0100, 16'h0100, 1'b0);
    run_op(2'b00, 16'hFFFF, 16'hFFFF, 1'b0);
    run_op(2'b01, 16'd5, 16'd5, 1'b0);
    run_op(2'b01, 16'd3, 16'd7, 1'b0);
    run_op(2'b10, 16'd9, 16'd0, 1'b0);
    run_op(2'b01, 16'd20, 16'd4, 1'b0);
    run_op(2'b00, 16'h1234, 16'h0ABC, 1'b1);

    // Asynchronous reset in the middle of a MUL
    start = 1'b1; cmd = 2'b00; op_a = 16'hBEEF; op_b = 16'h00FF;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_outs", {done, result, zero, neg, err}, 20'h0);
    chk("mid_rst_alu", {alu_a, alu_b, alu_op}, 35'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(2'b00, 16'd7, 16'd6, 1'b0);

    for (int n = 0; n < 16; n++) begin
      logic [1:0]  rc;
      logic [15:0] ra, rb;
      rc = 2'($urandom_range(0, 3));
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (n % 4 == 0) rb = 16'($urandom_range(0, 3));
      run_op(rc, ra, rb, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
